// File: rtl/count_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_sched_pkg
// Description : Shared types, default sizes and the round-robin pick helper
//               for the shared-counter job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package count_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    // Upper bound on requesters the pick helper can scan.
    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // First requester with valid set, scanning upward from last+1 with wrap
    // modulo n. Returns last when nothing is pending (caller gates on |valid).
    function automatic int unsigned rr_next(input int unsigned last,
                                            input logic [MAX_REQ-1:0] valid,
                                            input int unsigned n);
        int unsigned result;
        int unsigned idx;
        logic        found;
        result = last;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if ((k <= n) && !found) begin
                // last < n and k <= n, so a single subtraction wraps correctly
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[MAX_REQ_W-1:0]]) begin
                    result = idx;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage : count_sched_pkg
`default_nettype wire

// File: rtl/count_sched_load_counter.sv
`default_nettype none
// ============================================================================
// Module      : load_counter
// Description : WIDTH-bit up-counter with synchronous clear and enable.
//               Clear wins over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module load_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;

    // Count register: reset/clear to zero, otherwise step by one when enabled
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_value <= '0;
        end else if (i_enable) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule : load_counter
`default_nettype wire

// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module      : count_sched
// Description : Round-robin scheduler sharing one up-counter between NREQ
//               requesters. Accepts a terminal count, counts 0..limit (or
//               until aborted), pulses the owner's done, then re-arbitrates.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sched
    import count_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_limit,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  abort,
    output logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic [NREQ-1:0]       done,
    output logic                  done_abort
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_limit;
    logic [IDW-1:0]     r_grant;
    logic [IDW-1:0]     r_rr_last;
    logic [NREQ-1:0]    r_done;
    logic               r_done_abort;

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [IDW-1:0]     w_sel;
    logic               w_accept;
    logic               w_terminal;
    logic               w_enable;
    logic [WIDTH-1:0]   w_value;
    logic [NREQ-1:0]    w_grant_oh;
    logic [WIDTH-1:0]   w_limits [NREQ];

    // Widen the request vector to the helper's fixed scan width
    always_comb begin
        w_valid_ext            = '0;
        w_valid_ext[NREQ-1:0]  = req_valid;
    end

    assign w_sel      = IDW'(rr_next(32'(r_rr_last), w_valid_ext, NREQ));
    assign w_accept   = (r_state == ST_IDLE) && (|req_valid);
    assign w_terminal = (w_value == r_limit);
    // Count only while running and neither stop condition is present
    assign w_enable   = (r_state == ST_RUN) && !abort && !w_terminal;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_limits[gi]   = req_limit[gi*WIDTH +: WIDTH];
            assign req_ready[gi]  = w_accept && (w_sel == IDW'(gi));
            assign w_grant_oh[gi] = (r_grant == IDW'(gi));
        end
    endgenerate

    load_counter #(
        .WIDTH    (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_accept),
        .i_enable (w_enable),
        .o_value  (w_value)
    );

    // Job sequencing: accept in IDLE, count in RUN, one-cycle done in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_limit      <= '0;
            r_grant      <= '0;
            r_rr_last    <= IDW'(NREQ - 1);
            r_done       <= '0;
            r_done_abort <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done       <= '0;
                    r_done_abort <= 1'b0;
                    if (w_accept) begin
                        r_limit <= w_limits[w_sel];
                        r_grant <= w_sel;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort outranks a coincident terminal count
                    if (abort) begin
                        r_state      <= ST_DONE;
                        r_done       <= w_grant_oh;
                        r_done_abort <= 1'b1;
                    end else if (w_terminal) begin
                        r_state      <= ST_DONE;
                        r_done       <= w_grant_oh;
                        r_done_abort <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_rr_last    <= r_grant;
                    r_done       <= '0;
                    r_done_abort <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_done       <= '0;
                    r_done_abort <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign value      = w_value;
    assign busy       = (r_state != ST_IDLE);
    assign grant_id   = r_grant;
    assign done       = r_done;
    assign done_abort = r_done_abort;

endmodule : count_sched
`default_nettype wire

// File: tb/tb_count_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sched
// Description : Self-checking bench for count_sched: job-level reference
//               model compared every cycle plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_limit = '0;
    logic                  abort = 1'b0;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic [IDW-1:0]        grant_id;
    logic [NREQ-1:0]       done;
    logic                  done_abort;

    count_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_limit  (req_limit),
        .req_ready  (req_ready),
        .abort      (abort),
        .value      (value),
        .busy       (busy),
        .grant_id   (grant_id),
        .done       (done),
        .done_abort (done_abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tb_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Job-level reference: a job is (start edge, limit, owner); its value is
    // the number of edges since acceptance until it stops.
    int cyc      = 0;
    bit m_job    = 1'b0;
    bit m_stop   = 1'b0;
    bit m_dab    = 1'b0;
    int m_t0     = 0;
    int m_lim    = 0;
    int m_grant  = 0;
    int m_last   = NREQ - 1;
    int m_value  = 0;

    always @(posedge clk) begin : model
        int r;
        int sel;
        cyc++;
        if (reset) begin
            m_job   = 1'b0;
            m_stop  = 1'b0;
            m_value = 0;
            m_grant = 0;
            m_last  = NREQ - 1;
        end else if (m_job) begin
            if (m_stop) begin
                m_job  = 1'b0;
                m_stop = 1'b0;
                m_last = m_grant;
            end else begin
                r = cyc - m_t0;
                if (abort) begin
                    m_stop = 1'b1; m_dab = 1'b1; m_value = r - 1;
                end else if (r - 1 == m_lim) begin
                    m_stop = 1'b1; m_dab = 1'b0; m_value = r - 1;
                end else begin
                    m_value = r;
                end
            end
        end else if (|req_valid) begin
            sel     = tb_pick(m_last, req_valid);
            m_job   = 1'b1;
            m_t0    = cyc;
            m_lim   = int'(req_limit[sel*WIDTH +: WIDTH]);
            m_grant = sel;
            m_value = 0;
        end
    end

    // Every-cycle comparison of the DUT against the reference
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (chk_en) begin : cmp
                int e_ready;
                int e_done;
                e_ready = (!m_job && (|req_valid)) ? (1 << tb_pick(m_last, req_valid)) : 0;
                e_done  = (m_job && m_stop) ? (1 << m_grant) : 0;
                chk("busy",       int'(busy),       int'(m_job));
                chk("value",      int'(value),      m_value);
                chk("grant_id",   int'(grant_id),   m_grant);
                chk("done",       int'(done),       e_done);
                chk("done_abort", int'(done_abort), (m_job && m_stop && m_dab) ? 1 : 0);
                chk("req_ready",  int'(req_ready),  e_ready);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    // Raise req_valid[who] with limit L, wait for its accept, then drop it.
    // Returns at the negedge following the accept edge.
    task automatic submit(input int who, input int lim);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_valid[who] = 1'b1;
        req_limit[who*WIDTH +: WIDTH] = lim[WIDTH-1:0];
        for (int n = 0; n < 50; n++) begin
            #2;
            if (req_ready[who]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[who] = 1'b0;
    endtask

    // Wait for a done pulse; edges = index of the edge (after accept) that
    // samples done high. Optionally assert abort for one edge once value has
    // been seen equal to abort_after. Called at a negedge.
    task automatic run_wait(input int abort_after, output int edges,
                            output int dv, output int dab, output int val);
        bit pend;
        bit armed;
        int n;
        pend = 1'b0; armed = 1'b0; n = 0;
        edges = -1; dv = 0; dab = 0; val = -1;
        while (n < 400) begin
            abort = pend;
            pend  = 1'b0;
            #2;
            if (done != '0) begin
                edges = n + 1; dv = int'(done); dab = int'(done_abort); val = int'(value);
                break;
            end
            if (abort_after >= 0 && !armed && busy && int'(value) == abort_after) begin
                pend  = 1'b1;
                armed = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        abort = 1'b0;
        if (edges < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin : stim
        int e, d, ab, v;
        int exp_own [4];
        exp_own = '{0, 1, 0, 1};

        // Reset held for two edges
        @(negedge clk); chk_en = 1'b1;
        @(negedge clk); reset = 1'b0;
        #2;
        chk("rst_busy",  int'(busy), 0);
        chk("rst_value", int'(value), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_grant", int'(grant_id), 0);

        // Single job, limit 5
        submit(0, 5);
        run_wait(-1, e, d, ab, v);
        chk("l5_edges", e, 7);
        chk("l5_done", d, 1);
        chk("l5_dab", ab, 0);
        chk("l5_value", v, 5);
        @(negedge clk); #2;
        chk("l5_idle_after", int'(busy), 0);

        // Both requesters pending: strict alternation starting at 0
        do_reset();
        req_limit = {8'd2, 8'd3};
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            run_wait(-1, e, d, ab, v);
            chk("rr_owner", (d == 2) ? 1 : ((d == 1) ? 0 : -1), exp_own[j]);
            chk("rr_dab", ab, 0);
            chk("rr_value", v, (exp_own[j] == 0) ? 3 : 2);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Boundary limits
        submit(0, 0);
        run_wait(-1, e, d, ab, v);
        chk("l0_edges", e, 2);
        chk("l0_value", v, 0);
        submit(0, 255);
        run_wait(-1, e, d, ab, v);
        chk("l255_edges", e, 257);
        chk("l255_value", v, 255);
        chk("l255_done", d, 1);

        // Abort mid-count, then abort coinciding with terminal count
        submit(1, 10);
        run_wait(3, e, d, ab, v);
        chk("abort4_value", v, 4);
        chk("abort4_dab", ab, 1);
        chk("abort4_done", d, 2);
        submit(0, 10);
        run_wait(9, e, d, ab, v);
        chk("abort10_value", v, 10);
        chk("abort10_dab", ab, 1);
        chk("abort10_done", d, 1);
        submit(1, 1);
        run_wait(-1, e, d, ab, v);
        chk("post_abort_edges", e, 3);
        chk("post_abort_dab", ab, 0);
        chk("post_abort_done", d, 2);

        // Reset in the middle of a job
        submit(1, 10);
        for (int n = 0; n < 20; n++) begin
            #2;
            if (int'(value) == 2) break;
            @(negedge clk);
        end
        @(negedge clk); reset = 1'b1;
        #2;
        chk("pre_reset_value", int'(value), 3);
        @(negedge clk); reset = 1'b0;
        #2;
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_value", int'(value), 0);
        chk("mid_rst_done",  int'(done), 0);
        @(negedge clk);
        req_limit = {8'd1, 8'd1};
        req_valid = 2'b11;
        #2;
        chk("prio_after_reset", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b00;
        run_wait(-1, e, d, ab, v);
        chk("prio_done", d, 1);

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_count_sched
`default_nettype wire
